// File: rtl/cpu_mem_pkg.sv
// Shared types and address decode for the Hack-style CPU memory subsystem.
// Optional load checksum is enabled with CPU_MEM_CHECKSUM_EN (see top).
package cpu_mem_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN
   } state_t;

   typedef enum logic [1:0] {
      REG_RAM,
      REG_IO,
      REG_UNMAPPED
   } region_t;

   localparam int DEF_DATA_WORDS = 16384;
   localparam int DEF_IO_BASE    = 24576;
   localparam int IO_IDX_W       = 4;

   function automatic region_t decode(
      input int unsigned addr,
      input int unsigned data_words,
      input int unsigned io_base,
      input int unsigned io_channels
   );
      if (addr < data_words)
         return REG_RAM;
      if (addr >= io_base && addr < io_base + io_channels)
         return REG_IO;
      return REG_UNMAPPED;
   endfunction

endpackage

// File: rtl/cpu_mem_subsys_sync_ram.sv
// Single-port RAM, synchronous read-before-write, no reset on contents.
// Used for both program memory and data RAM.
module sync_ram #(
   parameter int WORDS      = 16,
   parameter int WORD_WIDTH = 16,
   localparam int AW        = (WORDS > 1) ? $clog2(WORDS) : 1
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [AW-1:0]         addr,
   input  logic [WORD_WIDTH-1:0] wdata,
   output logic [WORD_WIDTH-1:0] rdata
);

   logic [WORD_WIDTH-1:0] mem [WORDS];

   // Registered read returns the old word when written in the same cycle
   always_ff @(posedge clk) begin
      rdata <= mem[addr];
      if (we)
         mem[addr] <= wdata;
   end

endmodule

// File: rtl/cpu_mem_subsys.sv
// Program memory, data RAM, I/O bank and byte-serial program loader.
// Define CPU_MEM_CHECKSUM_EN to get a running sum of loaded words.
module cpu_mem_subsys
   import cpu_mem_pkg::*;
#(
   parameter int WORD_WIDTH  = 16,
   parameter int ADDR_WIDTH  = 15,
   parameter int PROG_WORDS  = 32768,
   parameter int DATA_WORDS  = DEF_DATA_WORDS,
   parameter int IO_BASE     = DEF_IO_BASE,
   parameter int IO_CHANNELS = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   output logic                              cpu_reset_o,
   input  logic [ADDR_WIDTH-1:0]             instr_addr_i,
   output logic [WORD_WIDTH-1:0]             instr_o,
   input  logic [ADDR_WIDTH-1:0]             mem_addr_i,
   input  logic                              mem_we_i,
   input  logic [WORD_WIDTH-1:0]             mem_wdata_i,
   output logic [WORD_WIDTH-1:0]             mem_rdata_o,
   input  logic                              load_start_i,
   input  logic                              load_end_i,
   input  logic                              load_valid_i,
   output logic                              load_ready_o,
   input  logic [7:0]                        load_byte_i,
   output logic                              load_overflow_o,
   output logic [WORD_WIDTH-1:0]             load_sum_o,
   output logic [IO_CHANNELS*WORD_WIDTH-1:0] io_out_o,
   input  logic [IO_CHANNELS*WORD_WIDTH-1:0] io_in_i
);

   localparam int PAW = (PROG_WORDS > 1) ? $clog2(PROG_WORDS) : 1;
   localparam int DAW = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
   localparam logic [PAW:0] PROG_LIM = (PAW + 1)'(PROG_WORDS);

   state_t state, state_nx;

   logic [PAW:0]          ptr;
   logic                  pending;
   logic [7:0]            lo_q;
   logic                  overflow;
   logic                  cpu_rst_q;
   logic                  accept;
   logic                  word_done;
   logic                  room;
   logic [WORD_WIDTH-1:0] word;

   logic                  prog_we;
   logic [PAW-1:0]        prog_addr;
   logic [WORD_WIDTH-1:0] prog_rdata;
   logic                  instr_ok;

   region_t               region;
   logic [ADDR_WIDTH-1:0] io_off;
   logic [IO_IDX_W-1:0]   ch;
   logic                  run;
   logic                  ram_we;
   logic [WORD_WIDTH-1:0] ram_rdata;
   logic                  sel_ram;
   logic                  sel_io;
   logic [WORD_WIDTH-1:0] io_rd;
   logic [WORD_WIDTH-1:0] io_rd_q;

   logic [IO_CHANNELS-1:0][WORD_WIDTH-1:0] io_q;
   logic [IO_CHANNELS-1:0][WORD_WIDTH-1:0] io_in_w;

   assign run       = (state == RUN);
   assign accept    = (state == LOAD) && load_valid_i && !load_start_i;
   assign word_done = accept && pending;
   assign room      = (ptr < PROG_LIM);
   assign word      = WORD_WIDTH'({load_byte_i, lo_q});

   assign load_ready_o    = (state == LOAD);
   assign load_overflow_o = overflow;
   assign cpu_reset_o     = cpu_rst_q;

   // State register
   always_ff @(posedge clk) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   // Next state; a start pulse beats a simultaneous end pulse
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (load_start_i) state_nx = LOAD;
         LOAD: begin
            if (load_start_i)
               state_nx = LOAD;
            else if (load_end_i)
               state_nx = RUN;
         end
         RUN:     if (load_start_i) state_nx = LOAD;
         default: state_nx = IDLE;
      endcase
   end

   // Loader byte pairing, write pointer and sticky overflow
   always_ff @(posedge clk) begin
      if (reset || load_start_i) begin
         ptr      <= '0;
         pending  <= 1'b0;
         lo_q     <= '0;
         overflow <= 1'b0;
      end else begin
         if (accept) begin
            if (!pending) begin
               lo_q    <= load_byte_i;
               pending <= 1'b1;
            end else begin
               pending <= 1'b0;
               if (room)
                  ptr <= ptr + 1'b1;
               else
                  overflow <= 1'b1;
            end
         end
         if (state == LOAD && load_end_i)
            pending <= 1'b0;
      end
   end

`ifdef CPU_MEM_CHECKSUM_EN
   logic [WORD_WIDTH-1:0] sum_q;

   // Running sum of words that actually reached program memory
   always_ff @(posedge clk) begin
      if (reset || load_start_i)
         sum_q <= '0;
      else if (word_done && room)
         sum_q <= sum_q + word;
   end

   assign load_sum_o = sum_q;
`else
   assign load_sum_o = '0;
`endif

   // CPU held in reset until one cycle after entering RUN
   always_ff @(posedge clk) begin
      if (reset)
         cpu_rst_q <= 1'b1;
      else
         cpu_rst_q <= !run;
   end

   assign prog_we   = word_done && room;
   assign prog_addr = (state == LOAD) ? ptr[PAW-1:0]
                                      : instr_addr_i[PAW-1:0];

   sync_ram #(
      .WORDS      (PROG_WORDS),
      .WORD_WIDTH (WORD_WIDTH)
   ) u_prog (
      .clk   (clk),
      .we    (prog_we),
      .addr  (prog_addr),
      .wdata (word),
      .rdata (prog_rdata)
   );

   // Fetch result is only exposed in RUN and for in-range addresses
   always_ff @(posedge clk) begin
      if (reset)
         instr_ok <= 1'b0;
      else
         instr_ok <= run && (32'(instr_addr_i) < 32'(PROG_WORDS));
   end

   assign instr_o = instr_ok ? prog_rdata : '0;

   assign region = decode(32'(mem_addr_i), DATA_WORDS,
                          IO_BASE, IO_CHANNELS);
   assign io_off = mem_addr_i - ADDR_WIDTH'(IO_BASE);
   assign ch     = io_off[IO_IDX_W-1:0];
   assign ram_we = run && mem_we_i && (region == REG_RAM);

   sync_ram #(
      .WORDS      (DATA_WORDS),
      .WORD_WIDTH (WORD_WIDTH)
   ) u_data (
      .clk   (clk),
      .we    (ram_we),
      .addr  (mem_addr_i[DAW-1:0]),
      .wdata (mem_wdata_i),
      .rdata (ram_rdata)
   );

   assign io_in_w  = io_in_i;
   assign io_out_o = io_q;

   // Select the addressed input channel
   always_comb begin
      io_rd = '0;
      for (int i = 0; i < IO_CHANNELS; i++)
         if (ch == IO_IDX_W'(i))
            io_rd = io_in_w[i];
   end

   // Output channel registers, written by the CPU in RUN only
   always_ff @(posedge clk) begin
      if (reset) begin
         io_q <= '0;
      end else if (run && mem_we_i && region == REG_IO) begin
         for (int i = 0; i < IO_CHANNELS; i++)
            if (ch == IO_IDX_W'(i))
               io_q[i] <= mem_wdata_i;
      end
   end

   // Remember which region the read came from for the return mux
   always_ff @(posedge clk) begin
      if (reset) begin
         sel_ram <= 1'b0;
         sel_io  <= 1'b0;
         io_rd_q <= '0;
      end else begin
         sel_ram <= (region == REG_RAM);
         sel_io  <= (region == REG_IO);
         io_rd_q <= io_rd;
      end
   end

   assign mem_rdata_o = sel_ram ? ram_rdata :
                        sel_io  ? io_rd_q   : '0;

endmodule

// File: tb/tb_cpu_mem_subsys.sv
// Directed self-checking bench for cpu_mem_subsys (PROG_WORDS=4).
// Checksum expectations follow CPU_MEM_CHECKSUM_EN.
module tb_cpu_mem_subsys;

   localparam int W   = 16;
   localparam int AW  = 15;
   localparam int PW  = 4;
   localparam int DW  = 16384;
   localparam int IOB = 24576;
   localparam int NCH = 4;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            cpu_reset;
   logic [AW-1:0]   instr_addr = '0;
   logic [W-1:0]    instr;
   logic [AW-1:0]   mem_addr = '0;
   logic            mem_we = 1'b0;
   logic [W-1:0]    mem_wdata = '0;
   logic [W-1:0]    mem_rdata;
   logic            load_start = 1'b0;
   logic            load_end = 1'b0;
   logic            load_valid = 1'b0;
   logic            load_ready;
   logic [7:0]      load_byte = '0;
   logic            load_overflow;
   logic [W-1:0]    load_sum;
   logic [NCH*W-1:0] io_out;
   logic [NCH*W-1:0] io_in = '0;

   int n_chk  = 0;
   int n_fail = 0;

   cpu_mem_subsys #(
      .WORD_WIDTH  (W),
      .ADDR_WIDTH  (AW),
      .PROG_WORDS  (PW),
      .DATA_WORDS  (DW),
      .IO_BASE     (IOB),
      .IO_CHANNELS (NCH)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .cpu_reset_o     (cpu_reset),
      .instr_addr_i    (instr_addr),
      .instr_o         (instr),
      .mem_addr_i      (mem_addr),
      .mem_we_i        (mem_we),
      .mem_wdata_i     (mem_wdata),
      .mem_rdata_o     (mem_rdata),
      .load_start_i    (load_start),
      .load_end_i      (load_end),
      .load_valid_i    (load_valid),
      .load_ready_o    (load_ready),
      .load_byte_i     (load_byte),
      .load_overflow_o (load_overflow),
      .load_sum_o      (load_sum),
      .io_out_o        (io_out),
      .io_in_i         (io_in)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic put_byte(input logic [7:0] b);
      load_valid = 1'b1;
      load_byte  = b;
      step();
      load_valid = 1'b0;
   endtask

   task automatic start_load();
      load_start = 1'b1;
      step();
      load_start = 1'b0;
   endtask

   task automatic end_load();
      load_end = 1'b1;
      step();
      load_end = 1'b0;
      step();
   endtask

   task automatic fetch(input logic [AW-1:0] a);
      instr_addr = a;
      step();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      n_chk++;
      if (cpu_reset !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_cpu_reset got %b want 1", cpu_reset);
      end
      n_chk++;
      if (load_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_ready got %b want 0", load_ready);
      end
      n_chk++;
      if (load_overflow !== 1'b0 || load_sum !== 16'h0) begin
         n_fail++;
         $display("FAIL rst_load got ovf=%b sum=%h want 0/0",
                  load_overflow, load_sum);
      end
      n_chk++;
      if (instr !== 16'h0 || mem_rdata !== 16'h0) begin
         n_fail++;
         $display("FAIL rst_data got instr=%h rdata=%h want 0/0",
                  instr, mem_rdata);
      end
      n_chk++;
      if (io_out !== 64'h0) begin
         n_fail++;
         $display("FAIL rst_io got %h want 0", io_out);
      end
   endtask

   task automatic test_load();
      start_load();
      n_chk++;
      if (load_ready !== 1'b1 || cpu_reset !== 1'b1) begin
         n_fail++;
         $display("FAIL load_state got rdy=%b crst=%b want 1/1",
                  load_ready, cpu_reset);
      end
      put_byte(8'h34);
      put_byte(8'h12);
      put_byte(8'h78);
      put_byte(8'h56);
      instr_addr = 15'd1;
      load_end   = 1'b1;
      step();
      load_end = 1'b0;
      n_chk++;
      if (cpu_reset !== 1'b1) begin
         n_fail++;
         $display("FAIL crst_edge got %b want 1", cpu_reset);
      end
      step();
      n_chk++;
      if (cpu_reset !== 1'b0) begin
         n_fail++;
         $display("FAIL crst_run got %b want 0", cpu_reset);
      end
      n_chk++;
      if (instr !== 16'h5678) begin
         n_fail++;
         $display("FAIL fetch1 got %h want 5678", instr);
      end
      fetch(15'd0);
      n_chk++;
      if (instr !== 16'h1234) begin
         n_fail++;
         $display("FAIL fetch0 got %h want 1234", instr);
      end
   endtask

   task automatic test_ram();
      mem_addr  = 15'd100;
      mem_we    = 1'b1;
      mem_wdata = 16'hBEEF;
      step();
      mem_we = 1'b0;
      step();
      n_chk++;
      if (mem_rdata !== 16'hBEEF) begin
         n_fail++;
         $display("FAIL ram_rd got %h want beef", mem_rdata);
      end
      mem_we    = 1'b1;
      mem_wdata = 16'hAAAA;
      step();
      mem_we = 1'b0;
      n_chk++;
      if (mem_rdata !== 16'hBEEF) begin
         n_fail++;
         $display("FAIL ram_rbw got %h want beef", mem_rdata);
      end
      step();
      n_chk++;
      if (mem_rdata !== 16'hAAAA) begin
         n_fail++;
         $display("FAIL ram_new got %h want aaaa", mem_rdata);
      end
   endtask

   task automatic test_io();
      mem_addr  = 15'(IOB + 2);
      mem_we    = 1'b1;
      mem_wdata = 16'h0F0F;
      step();
      mem_we = 1'b0;
      n_chk++;
      if (io_out !== 64'h0000_0F0F_0000_0000) begin
         n_fail++;
         $display("FAIL io_wr got %h want 00000f0f00000000", io_out);
      end
      io_in    = 64'h4444_3333_1111_AAAA;
      mem_addr = 15'(IOB + 1);
      step();
      n_chk++;
      if (mem_rdata !== 16'h1111) begin
         n_fail++;
         $display("FAIL io_rd1 got %h want 1111", mem_rdata);
      end
      mem_addr = 15'(IOB + 3);
      step();
      n_chk++;
      if (mem_rdata !== 16'h4444) begin
         n_fail++;
         $display("FAIL io_rd3 got %h want 4444", mem_rdata);
      end
      mem_addr  = 15'(IOB + 4);
      mem_we    = 1'b1;
      mem_wdata = 16'hFFFF;
      step();
      mem_we = 1'b0;
      n_chk++;
      if (io_out !== 64'h0000_0F0F_0000_0000 || mem_rdata !== 16'h0) begin
         n_fail++;
         $display("FAIL io_unmapped got io=%h rd=%h want 00000f0f00000000/0",
                  io_out, mem_rdata);
      end
      // 20000 aliases RAM word 3616 if the decode is wrong
      mem_addr  = 15'd3616;
      mem_we    = 1'b1;
      mem_wdata = 16'h0000;
      step();
      mem_addr  = 15'd20000;
      mem_wdata = 16'h5555;
      step();
      mem_we = 1'b0;
      n_chk++;
      if (mem_rdata !== 16'h0) begin
         n_fail++;
         $display("FAIL unmap_rd got %h want 0", mem_rdata);
      end
      mem_addr = 15'd3616;
      step();
      n_chk++;
      if (mem_rdata !== 16'h0) begin
         n_fail++;
         $display("FAIL unmap_wr got %h want 0", mem_rdata);
      end
   endtask

   task automatic test_overflow();
      logic [W-1:0] exp_sum;
`ifdef CPU_MEM_CHECKSUM_EN
      exp_sum = 16'hAAAA;
`else
      exp_sum = 16'h0;
`endif
      start_load();
      mem_addr  = 15'd100;
      mem_we    = 1'b1;
      mem_wdata = 16'h1234;
      put_byte(8'h11);
      mem_we = 1'b0;
      n_chk++;
      if (instr !== 16'h0) begin
         n_fail++;
         $display("FAIL instr_load got %h want 0", instr);
      end
      put_byte(8'h11);
      put_byte(8'h22);
      put_byte(8'h22);
      put_byte(8'h33);
      put_byte(8'h33);
      put_byte(8'h44);
      put_byte(8'h44);
      n_chk++;
      if (load_overflow !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_early got %b want 0", load_overflow);
      end
      put_byte(8'h55);
      put_byte(8'h55);
      n_chk++;
      if (load_overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_set got %b want 1", load_overflow);
      end
      n_chk++;
      if (load_sum !== exp_sum) begin
         n_fail++;
         $display("FAIL ovf_sum got %h want %h", load_sum, exp_sum);
      end
      end_load();
      n_chk++;
      if (load_overflow !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_sticky got %b want 1", load_overflow);
      end
      fetch(15'd0);
      n_chk++;
      if (instr !== 16'h1111) begin
         n_fail++;
         $display("FAIL ovf_nowrap got %h want 1111", instr);
      end
      fetch(15'd3);
      n_chk++;
      if (instr !== 16'h4444) begin
         n_fail++;
         $display("FAIL ovf_last got %h want 4444", instr);
      end
      fetch(15'd4);
      n_chk++;
      if (instr !== 16'h0) begin
         n_fail++;
         $display("FAIL fetch_oor got %h want 0", instr);
      end
      mem_addr = 15'd100;
      step();
      n_chk++;
      if (mem_rdata !== 16'hAAAA) begin
         n_fail++;
         $display("FAIL load_we_ignored got %h want aaaa", mem_rdata);
      end
      start_load();
      n_chk++;
      if (load_overflow !== 1'b0 || load_sum !== 16'h0) begin
         n_fail++;
         $display("FAIL ovf_clear got ovf=%b sum=%h want 0/0",
                  load_overflow, load_sum);
      end
   endtask

   task automatic test_odd_byte();
      logic [W-1:0] exp_sum;
`ifdef CPU_MEM_CHECKSUM_EN
      exp_sum = 16'hABCD;
`else
      exp_sum = 16'h0;
`endif
      put_byte(8'hCD);
      put_byte(8'hAB);
      put_byte(8'hEF);
      end_load();
      fetch(15'd0);
      n_chk++;
      if (instr !== 16'hABCD) begin
         n_fail++;
         $display("FAIL odd_w0 got %h want abcd", instr);
      end
      fetch(15'd1);
      n_chk++;
      if (instr !== 16'h2222) begin
         n_fail++;
         $display("FAIL odd_w1 got %h want 2222", instr);
      end
      n_chk++;
      if (load_sum !== exp_sum) begin
         n_fail++;
         $display("FAIL odd_sum got %h want %h", load_sum, exp_sum);
      end
   endtask

   task automatic test_checksum();
      logic [W-1:0] exp_sum;
`ifdef CPU_MEM_CHECKSUM_EN
      exp_sum = 16'h0001;
`else
      exp_sum = 16'h0;
`endif
      start_load();
      put_byte(8'hFF);
      put_byte(8'hFF);
      put_byte(8'h02);
      put_byte(8'h00);
      n_chk++;
      if (load_sum !== exp_sum) begin
         n_fail++;
         $display("FAIL sum_wrap got %h want %h", load_sum, exp_sum);
      end
      end_load();
   endtask

   task automatic test_reset_mid_load();
      start_load();
      put_byte(8'h11);
      put_byte(8'h22);
      put_byte(8'h99);
      reset = 1'b1;
      step();
      reset = 1'b0;
      n_chk++;
      if (cpu_reset !== 1'b1 || load_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_rst got crst=%b rdy=%b want 1/0",
                  cpu_reset, load_ready);
      end
      load_start = 1'b1;
      load_end   = 1'b1;
      step();
      load_start = 1'b0;
      load_end   = 1'b0;
      n_chk++;
      if (load_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL start_wins got rdy=%b want 1", load_ready);
      end
      end_load();
      fetch(15'd0);
      n_chk++;
      if (instr !== 16'h2211) begin
         n_fail++;
         $display("FAIL persist got %h want 2211", instr);
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_ram();
      test_io();
      test_overflow();
      test_odd_byte();
      test_checksum();
      test_reset_mid_load();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
